completion_buffer: RTL and testbench

- In-order completion buffer (reorder buffer) for the out-of-order RISCVBusiness pipeline.
- Decode allocates one entry per issued instruction and receives the tail index as its tag.
- Functional units (ALU, multiply, divide, load/store) and the vector unit's scalar writeback mark tagged entries complete.
- The head entry retires in program order and drives the register-file write, the hazard-unit flush/exception signals and the vector commit handshake.

---
 rtl/completion_buffer.sv | 225 ++++++++++++++++++++++
 tb/tb_completion_buffer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/completion_buffer.sv
`default_nettype none
// ============================================================================
// Module   : completion_buffer
// Purpose  : In-order completion (reorder) buffer. Decode allocates one entry
//            per issued instruction and is handed the tail index as its tag.
//            The ALU, multiply, divide, load/store and vector scalar-result
//            ports mark tagged entries complete. The head entry retires in
//            program order. Retirement drives the register-file write, the
//            flush/exception signals and the vector commit handshake.
// Ports    : CLK, nRST (async, active low)
//            alloc_ena, rv32v_instr        -> cur_tail, full, empty
//            index/vd/wdata/exception/ready_{a,mu,du,ls}, wen_a,
//            branch_mispredict, mal_ls      functional-unit writeback
//            rv32v_wb_*                     vector scalar writeback
//            rv32v_commit_done/exception   -> rv32v_commit_ena
//            scalar_commit_ena, vd_final, wdata_final, flush, exception,
//            branch_mispredict_ena, mal_priv, tb_read   retire outputs
// Revision : 1.0 - initial release
// ============================================================================
module completion_buffer #(
  parameter int NUM_CB_ENTRY = 16,
  localparam int IW = $clog2(NUM_CB_ENTRY)
) (
  input  logic          CLK,
  input  logic          nRST,
  // allocation
  input  logic          alloc_ena,
  input  logic          rv32v_instr,
  output logic [IW-1:0] cur_tail,
  output logic          full,
  output logic          empty,
  // ALU writeback
  input  logic [IW-1:0] index_a,
  input  logic [4:0]    vd_a,
  input  logic [31:0]   wdata_a,
  input  logic          exception_a,
  input  logic          ready_a,
  input  logic          wen_a,
  input  logic          branch_mispredict,
  // multiply writeback
  input  logic [IW-1:0] index_mu,
  input  logic [4:0]    vd_mu,
  input  logic [31:0]   wdata_mu,
  input  logic          exception_mu,
  input  logic          ready_mu,
  // divide writeback
  input  logic [IW-1:0] index_du,
  input  logic [4:0]    vd_du,
  input  logic [31:0]   wdata_du,
  input  logic          exception_du,
  input  logic          ready_du,
  // load/store writeback
  input  logic [IW-1:0] index_ls,
  input  logic [4:0]    vd_ls,
  input  logic [31:0]   wdata_ls,
  input  logic          exception_ls,
  input  logic          ready_ls,
  input  logic          mal_ls,
  // vector scalar-result writeback
  input  logic          rv32v_wb_scalar_ready,
  input  logic [IW-1:0] rv32v_wb_scalar_index,
  input  logic [4:0]    rv32v_wb_vd,
  input  logic [31:0]   rv32v_wb_scalar_data,
  input  logic          rv32v_wb_exception,
  // vector commit handshake
  output logic          rv32v_commit_ena,
  input  logic          rv32v_commit_done,
  input  logic          rv32v_exception,
  // retire
  output logic          scalar_commit_ena,
  output logic [4:0]    vd_final,
  output logic [31:0]   wdata_final,
  output logic          flush,
  output logic          exception,
  output logic          branch_mispredict_ena,
  output logic          mal_priv,
  output logic          tb_read
);

  localparam logic [IW:0] c_FULL_COUNT = (IW+1)'(NUM_CB_ENTRY);

  // entry storage
  logic [NUM_CB_ENTRY-1:0] r_valid, r_done, r_vec, r_wen, r_exc, r_mispred, r_mal;
  logic [4:0]              r_vd    [NUM_CB_ENTRY];
  logic [31:0]             r_wdata [NUM_CB_ENTRY];

  logic [IW-1:0] r_head, r_tail;
  logic [IW:0]   r_count;

  // head entry view
  logic w_h_valid, w_h_done, w_h_vec, w_h_exc;
  logic w_scalar_exc, w_vec_done, w_vec_retire, w_vec_exc;
  logic w_retire, w_alloc, w_flush;

  assign w_h_valid = r_valid[r_head];
  assign w_h_done  = r_done[r_head];
  assign w_h_vec   = r_vec[r_head];
  assign w_h_exc   = r_exc[r_head];

  assign full     = (r_count == c_FULL_COUNT);
  assign empty    = (r_count == '0);
  assign cur_tail = r_tail;

  assign scalar_commit_ena     = w_h_valid & w_h_done & ~w_h_vec & ~w_h_exc;
  assign branch_mispredict_ena = scalar_commit_ena & r_mispred[r_head];
  assign vd_final              = (scalar_commit_ena & r_wen[r_head]) ? r_vd[r_head] : 5'd0;
  assign wdata_final           = scalar_commit_ena ? r_wdata[r_head] : 32'd0;

  assign w_scalar_exc     = w_h_valid & w_h_done & w_h_exc & ~w_h_vec;
  assign rv32v_commit_ena = w_h_valid & w_h_vec;
  assign w_vec_done       = rv32v_commit_ena & rv32v_commit_done;
  assign w_vec_retire     = w_vec_done & ~rv32v_exception;
  assign w_vec_exc        = w_vec_done & rv32v_exception;

  assign exception = w_scalar_exc | w_vec_exc;
  assign mal_priv  = w_scalar_exc & r_mal[r_head];
  assign flush     = branch_mispredict_ena | exception;
  assign tb_read   = scalar_commit_ena | exception | w_vec_done;

  assign w_flush  = flush;
  assign w_retire = scalar_commit_ena | w_vec_retire;
  assign w_alloc  = alloc_ena & ~full;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      r_done    <= '0;
      r_vec     <= '0;
      r_wen     <= '0;
      r_exc     <= '0;
      r_mispred <= '0;
      r_mal     <= '0;
      for (int i = 0; i < NUM_CB_ENTRY; i++) begin
        r_vd[i]    <= '0;
        r_wdata[i] <= '0;
      end
    end else if (w_flush) begin
      // Squash everything; allocation and writebacks this cycle are lost.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      // Writeback: only to live entries not being re-allocated this cycle.
      // The if/else chain gives a > mu > du > ls > vector on index collisions.
      for (int i = 0; i < NUM_CB_ENTRY; i++) begin
        if (r_valid[i] && !(w_alloc && (r_tail == IW'(i)))) begin
          if (ready_a && (index_a == IW'(i))) begin
            r_done[i]    <= 1'b1;
            r_vd[i]      <= vd_a;
            r_wdata[i]   <= wdata_a;
            r_exc[i]     <= exception_a;
            r_wen[i]     <= wen_a;
            r_mispred[i] <= branch_mispredict;
            r_mal[i]     <= 1'b0;
          end else if (ready_mu && (index_mu == IW'(i))) begin
            r_done[i]    <= 1'b1;
            r_vd[i]      <= vd_mu;
            r_wdata[i]   <= wdata_mu;
            r_exc[i]     <= exception_mu;
            r_wen[i]     <= |vd_mu;
            r_mispred[i] <= 1'b0;
            r_mal[i]     <= 1'b0;
          end else if (ready_du && (index_du == IW'(i))) begin
            r_done[i]    <= 1'b1;
            r_vd[i]      <= vd_du;
            r_wdata[i]   <= wdata_du;
            r_exc[i]     <= exception_du;
            r_wen[i]     <= |vd_du;
            r_mispred[i] <= 1'b0;
            r_mal[i]     <= 1'b0;
          end else if (ready_ls && (index_ls == IW'(i))) begin
            r_done[i]    <= 1'b1;
            r_vd[i]      <= vd_ls;
            r_wdata[i]   <= wdata_ls;
            r_exc[i]     <= exception_ls;
            r_wen[i]     <= |vd_ls;
            r_mispred[i] <= 1'b0;
            r_mal[i]     <= mal_ls;
          end else if (rv32v_wb_scalar_ready && (rv32v_wb_scalar_index == IW'(i))) begin
            r_done[i]    <= 1'b1;
            r_vd[i]      <= rv32v_wb_vd;
            r_wdata[i]   <= rv32v_wb_scalar_data;
            r_exc[i]     <= rv32v_wb_exception;
            r_wen[i]     <= |rv32v_wb_vd;
            r_mispred[i] <= 1'b0;
            r_mal[i]     <= 1'b0;
          end
        end
      end

      // Clearing valid on retire makes late writebacks to the freed slot drop.
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end

      // Allocation never targets the head slot unless full, which blocks it.
      if (w_alloc) begin
        r_valid[r_tail]   <= 1'b1;
        r_done[r_tail]    <= 1'b0;
        r_vec[r_tail]     <= rv32v_instr;
        r_wen[r_tail]     <= 1'b0;
        r_exc[r_tail]     <= 1'b0;
        r_mispred[r_tail] <= 1'b0;
        r_mal[r_tail]     <= 1'b0;
        r_vd[r_tail]      <= '0;
        r_wdata[r_tail]   <= '0;
        r_tail            <= r_tail + 1'b1;
      end

      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_completion_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_completion_buffer
// Purpose  : Directed self-checking bench for completion_buffer. Expected
//            retire results are queued in program order as entries are
//            allocated and popped whenever the DUT retires a scalar entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_completion_buffer;

  localparam int N  = 16;
  localparam int IW = 4;

  typedef struct packed {
    logic [4:0]  vd;
    logic [31:0] wd;
    logic        mp;
  } exp_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          alloc_ena, rv32v_instr;
  logic [IW-1:0] cur_tail;
  logic          full, empty;
  logic [IW-1:0] index_a, index_mu, index_du, index_ls;
  logic [4:0]    vd_a, vd_mu, vd_du, vd_ls;
  logic [31:0]   wdata_a, wdata_mu, wdata_du, wdata_ls;
  logic          exception_a, exception_mu, exception_du, exception_ls;
  logic          ready_a, ready_mu, ready_du, ready_ls;
  logic          wen_a, branch_mispredict, mal_ls;
  logic          rv32v_wb_scalar_ready;
  logic [IW-1:0] rv32v_wb_scalar_index;
  logic [4:0]    rv32v_wb_vd;
  logic [31:0]   rv32v_wb_scalar_data;
  logic          rv32v_wb_exception;
  logic          rv32v_commit_ena, rv32v_commit_done, rv32v_exception;
  logic          scalar_commit_ena;
  logic [4:0]    vd_final;
  logic [31:0]   wdata_final;
  logic          flush, exception, branch_mispredict_ena, mal_priv, tb_read;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [4:0]  tag_vd [N];
  logic [31:0] tag_wd [N];

  always #5 CLK = ~CLK;

  completion_buffer #(.NUM_CB_ENTRY(N)) dut (
    .CLK(CLK), .nRST(nRST),
    .alloc_ena(alloc_ena), .rv32v_instr(rv32v_instr),
    .cur_tail(cur_tail), .full(full), .empty(empty),
    .index_a(index_a), .vd_a(vd_a), .wdata_a(wdata_a), .exception_a(exception_a),
    .ready_a(ready_a), .wen_a(wen_a), .branch_mispredict(branch_mispredict),
    .index_mu(index_mu), .vd_mu(vd_mu), .wdata_mu(wdata_mu),
    .exception_mu(exception_mu), .ready_mu(ready_mu),
    .index_du(index_du), .vd_du(vd_du), .wdata_du(wdata_du),
    .exception_du(exception_du), .ready_du(ready_du),
    .index_ls(index_ls), .vd_ls(vd_ls), .wdata_ls(wdata_ls),
    .exception_ls(exception_ls), .ready_ls(ready_ls), .mal_ls(mal_ls),
    .rv32v_wb_scalar_ready(rv32v_wb_scalar_ready),
    .rv32v_wb_scalar_index(rv32v_wb_scalar_index),
    .rv32v_wb_vd(rv32v_wb_vd), .rv32v_wb_scalar_data(rv32v_wb_scalar_data),
    .rv32v_wb_exception(rv32v_wb_exception),
    .rv32v_commit_ena(rv32v_commit_ena), .rv32v_commit_done(rv32v_commit_done),
    .rv32v_exception(rv32v_exception),
    .scalar_commit_ena(scalar_commit_ena), .vd_final(vd_final),
    .wdata_final(wdata_final), .flush(flush), .exception(exception),
    .branch_mispredict_ena(branch_mispredict_ena), .mal_priv(mal_priv),
    .tb_read(tb_read)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive point: 2 time units after the rising edge
  task automatic next();
    @(posedge CLK);
    #2;
  endtask

  // sample point: 1 time unit after the falling edge
  task automatic sample();
    @(negedge CLK);
    #1;
  endtask

  task automatic clr();
    alloc_ena = 0; rv32v_instr = 0;
    index_a = '0; vd_a = '0; wdata_a = '0; exception_a = 0; ready_a = 0;
    wen_a = 0; branch_mispredict = 0;
    index_mu = '0; vd_mu = '0; wdata_mu = '0; exception_mu = 0; ready_mu = 0;
    index_du = '0; vd_du = '0; wdata_du = '0; exception_du = 0; ready_du = 0;
    index_ls = '0; vd_ls = '0; wdata_ls = '0; exception_ls = 0; ready_ls = 0; mal_ls = 0;
    rv32v_wb_scalar_ready = 0; rv32v_wb_scalar_index = '0; rv32v_wb_vd = '0;
    rv32v_wb_scalar_data = '0; rv32v_wb_exception = 0;
    rv32v_commit_done = 0; rv32v_exception = 0;
  endtask

  task automatic push(input logic [4:0] vd, input logic [31:0] wd, input logic mp);
    exp_t e;
    e.vd = vd; e.wd = wd; e.mp = mp;
    sb.push_back(e);
  endtask

  task automatic wb_a(input int idx, input logic [4:0] vd, input logic [31:0] wd,
                      input logic wen, input logic mp, input logic exc);
    ready_a = 1; index_a = IW'(idx); vd_a = vd; wdata_a = wd;
    wen_a = wen; branch_mispredict = mp; exception_a = exc;
  endtask

  task automatic wb_mu(input int idx, input logic [4:0] vd, input logic [31:0] wd);
    ready_mu = 1; index_mu = IW'(idx); vd_mu = vd; wdata_mu = wd;
  endtask

  task automatic wb_du(input int idx, input logic [4:0] vd, input logic [31:0] wd);
    ready_du = 1; index_du = IW'(idx); vd_du = vd; wdata_du = wd;
  endtask

  task automatic wb_ls(input int idx, input logic [4:0] vd, input logic [31:0] wd,
                       input logic exc, input logic mal);
    ready_ls = 1; index_ls = IW'(idx); vd_ls = vd; wdata_ls = wd;
    exception_ls = exc; mal_ls = mal;
  endtask

  task automatic do_reset();
    nRST = 0;
    clr();
    next();
    nRST = 1;
  endtask

  // scoreboard: every scalar retire must match the oldest queued expectation
  always @(negedge CLK) begin
    if (nRST === 1'b1 && scalar_commit_ena === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL retire_unexpected: observed vd 0x%0h data 0x%0h expected no retire",
               vd_final, wdata_final);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("retire_vd", 32'(vd_final), 32'(e.vd));
        chk("retire_wdata", wdata_final, e.wd);
        chk("retire_mispred", 32'(branch_mispredict_ena), 32'(e.mp));
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    clr();
    nRST = 0;
    next();
    sample();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_cur_tail", 32'(cur_tail), 0);
    chk("rst_commit", 32'(scalar_commit_ena), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_tb_read", 32'(tb_read), 0);
    next();
    nRST = 1;

    // ---------------- in-order retire of out-of-order completions ----------------
    for (int i = 0; i < 3; i++) begin
      clr(); alloc_ena = 1;
      sample(); chk("p1_cur_tail", 32'(cur_tail), 32'(i));
      next();
    end
    push(5'd1, 32'h1, 0);
    push(5'd3, 32'h3, 0);
    push(5'd5, 32'hA, 0);
    clr(); wb_ls(2, 5'd5, 32'hA, 0, 0);
    sample(); chk("p1_no_retire_tag2_only", 32'(scalar_commit_ena), 0);
    next();
    clr(); wb_a(0, 5'd1, 32'h1, 1, 0, 0);
    sample(); chk("p1_latency", 32'(scalar_commit_ena), 0);
    next();
    clr(); wb_mu(1, 5'd3, 32'h3);
    sample(); chk("p1_retire0", 32'(scalar_commit_ena), 1);
    next();
    clr();
    sample(); chk("p1_retire1", 32'(scalar_commit_ena), 1);
    next();
    sample(); chk("p1_retire2", 32'(scalar_commit_ena), 1);
    next();
    sample(); chk("p1_empty", 32'(empty), 1); chk("p1_sb", 32'(sb.size()), 0);
    next();

    // ---------------- full, wrap, concurrent alloc/retire ----------------
    do_reset();
    for (int i = 0; i < N; i++) begin
      clr(); alloc_ena = 1;
      tag_vd[i] = 5'(i + 1);
      tag_wd[i] = 32'h100 + 32'(i);
      push((i == 5) ? 5'd0 : tag_vd[i], tag_wd[i], 0);
      sample(); chk("p2_cur_tail", 32'(cur_tail), 32'(i)); chk("p2_not_full", 32'(full), 0);
      next();
    end
    clr(); alloc_ena = 1;                       // 17th request
    sample(); chk("p2_full", 32'(full), 1); chk("p2_tail_wrap", 32'(cur_tail), 0);
    next();
    clr(); wb_du(0, tag_vd[0], tag_wd[0]);
    sample(); chk("p2_17th_ignored", 32'(full), 1);
    next();
    clr();
    sample(); chk("p2_retire_full", 32'(scalar_commit_ena), 1); chk("p2_still_full", 32'(full), 1);
    next();
    clr(); alloc_ena = 1; wb_mu(1, tag_vd[1], tag_wd[1]);
    tag_vd[0] = 5'd17; tag_wd[0] = 32'h200; push(5'd17, 32'h200, 0);
    sample(); chk("p2_full_freed", 32'(full), 0); chk("p2_wrap_tag0", 32'(cur_tail), 0);
    next();
    clr(); alloc_ena = 1; wb_ls(2, tag_vd[2], tag_wd[2], 0, 0);
    sample(); chk("p2_full_again", 32'(full), 1); chk("p2_retire_t1", 32'(scalar_commit_ena), 1);
    next();
    clr(); alloc_ena = 1;
    tag_vd[1] = 5'd18; tag_wd[1] = 32'h201; push(5'd18, 32'h201, 0);
    sample(); chk("p2_blocked_alloc", 32'(cur_tail), 1); chk("p2_retire_t2", 32'(scalar_commit_ena), 1);
    next();
    clr();
    sample(); chk("p2_same_cycle_count", 32'(full), 0); chk("p2_tail2", 32'(cur_tail), 2);
    next();
    clr(); alloc_ena = 1;
    tag_vd[2] = 5'd19; tag_wd[2] = 32'h202; push(5'd19, 32'h202, 0);
    next();
    clr();
    sample(); chk("p2_count16", 32'(full), 1);
    next();
    for (int k = 0; k < N; k++) begin
      int t;
      t = (3 + k) % N;
      clr();
      if (t == 5) wb_a(t, tag_vd[t], tag_wd[t], 0, 0, 0);
      else if (t == 7) begin
        wb_a(t, tag_vd[t], tag_wd[t], 1, 0, 0);
        wb_ls(t, 5'd0, 32'hDEAD, 1, 1);
      end
      else if (k % 3 == 0) wb_mu(t, tag_vd[t], tag_wd[t]);
      else if (k % 3 == 1) wb_du(t, tag_vd[t], tag_wd[t]);
      else wb_ls(t, tag_vd[t], tag_wd[t], 0, 0);
      next();
    end
    clr();
    for (int w = 0; w < 20 && empty !== 1'b1; w++) next();
    sample(); chk("p2_drained", 32'(empty), 1); chk("p2_sb", 32'(sb.size()), 0);
    next();

    // ---------------- branch mispredict ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clr(); alloc_ena = 1;
      next();
    end
    push(5'd2, 32'h50, 0);
    push(5'd1, 32'h104, 1);
    clr(); wb_a(1, 5'd1, 32'h104, 1, 1, 0);
    sample(); chk("p3_wait_tag0", 32'(scalar_commit_ena), 0);
    next();
    clr(); wb_du(0, 5'd2, 32'h50);
    sample(); chk("p3_wait_tag0b", 32'(scalar_commit_ena), 0);
    next();
    clr();
    sample(); chk("p3_retire0", 32'(scalar_commit_ena), 1); chk("p3_noflush0", 32'(flush), 0);
    next();
    clr(); alloc_ena = 1; wb_mu(2, 5'd7, 32'h77);
    sample();
    chk("p3_retire_br", 32'(scalar_commit_ena), 1);
    chk("p3_flush", 32'(flush), 1);
    chk("p3_bme", 32'(branch_mispredict_ena), 1);
    chk("p3_tb_read", 32'(tb_read), 1);
    next();
    clr(); wb_ls(2, 5'd8, 32'h88, 0, 0); wb_mu(3, 5'd9, 32'h99);
    sample(); chk("p3_empty", 32'(empty), 1); chk("p3_cur_tail", 32'(cur_tail), 0);
    next();
    clr();
    sample(); chk("p3_late_wb_dropped", 32'(scalar_commit_ena), 0); chk("p3_empty2", 32'(empty), 1);
    next();
    clr(); alloc_ena = 1;
    sample(); chk("p3_realloc_tag0", 32'(cur_tail), 0);
    next();
    clr();
    sample(); chk("p3_realloc_not_done", 32'(scalar_commit_ena), 0); chk("p3_sb", 32'(sb.size()), 0);
    next();

    // ---------------- misaligned load/store exception ----------------
    clr(); wb_ls(0, 5'd4, 32'h44, 1, 1);
    sample(); chk("p4_pre_exc", 32'(exception), 0);
    next();
    clr();
    sample();
    chk("p4_exception", 32'(exception), 1);
    chk("p4_mal_priv", 32'(mal_priv), 1);
    chk("p4_flush", 32'(flush), 1);
    chk("p4_no_commit", 32'(scalar_commit_ena), 0);
    chk("p4_tb_read", 32'(tb_read), 1);
    next();
    clr();
    sample(); chk("p4_empty", 32'(empty), 1); chk("p4_exc_clear", 32'(exception), 0);
    next();

    // ---------------- vector commit handshake ----------------
    clr(); alloc_ena = 1; rv32v_instr = 1;
    sample(); chk("p5_no_vcommit", 32'(rv32v_commit_ena), 0);
    next();
    clr(); alloc_ena = 1; push(5'd9, 32'h99, 0);
    sample(); chk("p5_vcommit_c1", 32'(rv32v_commit_ena), 1);
    next();
    clr(); wb_a(1, 5'd9, 32'h99, 1, 0, 0);
    sample(); chk("p5_vcommit_c2", 32'(rv32v_commit_ena), 1); chk("p5_scalar_blocked", 32'(scalar_commit_ena), 0);
    next();
    clr();
    sample(); chk("p5_vcommit_c3", 32'(rv32v_commit_ena), 1);
    next();
    clr(); rv32v_commit_done = 1;
    sample();
    chk("p5_vdone_ena", 32'(rv32v_commit_ena), 1);
    chk("p5_vdone_tb_read", 32'(tb_read), 1);
    chk("p5_vdone_no_wr", 32'(scalar_commit_ena), 0);
    chk("p5_vdone_no_flush", 32'(flush), 0);
    next();
    clr();
    sample(); chk("p5_scalar_after_vec", 32'(scalar_commit_ena), 1); chk("p5_vcommit_off", 32'(rv32v_commit_ena), 0);
    next();
    sample(); chk("p5_empty", 32'(empty), 1); chk("p5_sb", 32'(sb.size()), 0);
    next();
    clr(); alloc_ena = 1; rv32v_instr = 1;
    next();
    clr(); alloc_ena = 1;
    sample(); chk("p5x_vcommit", 32'(rv32v_commit_ena), 1);
    next();
    clr(); wb_mu(3, 5'd4, 32'h4);
    sample(); chk("p5x_vcommit2", 32'(rv32v_commit_ena), 1);
    next();
    clr(); rv32v_commit_done = 1; rv32v_exception = 1;
    sample();
    chk("p5x_exception", 32'(exception), 1);
    chk("p5x_flush", 32'(flush), 1);
    chk("p5x_tb_read", 32'(tb_read), 1);
    chk("p5x_no_wr", 32'(scalar_commit_ena), 0);
    next();
    clr();
    sample(); chk("p5x_empty", 32'(empty), 1); chk("p5x_vcommit_off", 32'(rv32v_commit_ena), 0);
    next();

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 0; i < 5; i++) begin
      clr(); alloc_ena = 1;
      next();
    end
    clr();
    sample(); chk("p6_pending", 32'(empty), 0); chk("p6_tail5", 32'(cur_tail), 5);
    next();
    #1 nRST = 0;
    #1;
    chk("p6_async_empty", 32'(empty), 1);
    chk("p6_async_full", 32'(full), 0);
    chk("p6_async_tail", 32'(cur_tail), 0);
    chk("p6_async_commit", 32'(scalar_commit_ena), 0);
    chk("p6_async_vcommit", 32'(rv32v_commit_ena), 0);
    chk("p6_async_tb_read", 32'(tb_read), 0);
    next();
    nRST = 1; alloc_ena = 1;
    sample(); chk("p6_first_tag", 32'(cur_tail), 0);
    next();
    clr();
    sample(); chk("p6_second_tag", 32'(cur_tail), 1); chk("p6_not_empty", 32'(empty), 0);
    chk("final_sb", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
